user_pulse_sequencer: RTL and testbench

//  Program sequencer for the user-domain pulse generator. Holds a table of NUM_ENTRIES pulse

---
 rtl/user_pulse_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_user_pulse_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/user_pulse_sequencer.sv
// -----------------------------------------------------------------------------
// user_pulse_sequencer
//   Program sequencer for the user-domain pulse generator. Holds a table of
//   NUM_ENTRIES pulse programs and plays entries 0..n-1 back-to-back. A run
//   plays that list loops_i times, or forever when loops_i is 0. It drives the
//   generator's start/stop/config inputs and waits for the generator to report
//   DONE before moving to the next entry.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   wr_en_i/wr_idx_i/wr_field_i/wr_data_i
//                         table write port, honoured only while idle
//                         field 0: {f1_cnt, f2_cnt, stop_cnt, 8'h0}
//                         field 1: {f1_end, f1_switch}
//                         field 2: {f2_end, f2_switch}
//                         field 3: ignored
//   go_i                  start playback (idle only)
//   abort_i               abort playback (ignored while idle)
//   num_entries_i         entries per pass (clamped to NUM_ENTRIES)
//   loops_i               passes to play, 0 = forever
//   pls_state_i           generator state (4 = DONE)
//   pls_start_o/pls_stop_o  one-cycle generator commands
//   pls_*_o               registered config of the active entry
//   busy_o, done_o, aborted_o  status (done/aborted are one-cycle pulses)
//   entry_o, loop_o       active entry index, completed passes
//   state_o               FSM state, for debug visibility
//
// Generator handshake: pls_start_o is a one-cycle command issued while the
// config outputs are already stable. The generator has no ready signal, so the
// sequencer holds the config and waits in WAIT until pls_state_i reads DONE.
// pls_state_i is not examined in any other state, so a DONE left over from
// the previous entry is never mistaken for completion of the current one.
// -----------------------------------------------------------------------------
module user_pulse_sequencer #(
   parameter int NUM_ENTRIES = 8,
   parameter int IDX_W       = $clog2(NUM_ENTRIES),
   parameter int LOOP_W      = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [1:0]        wr_field_i,
   input  logic [31:0]       wr_data_i,
   input  logic              go_i,
   input  logic              abort_i,
   input  logic [IDX_W:0]    num_entries_i,
   input  logic [LOOP_W-1:0] loops_i,
   input  logic [2:0]        pls_state_i,
   output logic              pls_start_o,
   output logic              pls_stop_o,
   output logic [7:0]        pls_f1_cnt_o,
   output logic [7:0]        pls_f2_cnt_o,
   output logic [7:0]        pls_stop_cnt_o,
   output logic [15:0]       pls_f1_end_o,
   output logic [15:0]       pls_f1_switch_o,
   output logic [15:0]       pls_f2_end_o,
   output logic [15:0]       pls_f2_switch_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              aborted_o,
   output logic [IDX_W-1:0]  entry_o,
   output logic [LOOP_W-1:0] loop_o,
   output logic [2:0]        state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_START  = 3'd2,
      S_WAIT   = 3'd3,
      S_NEXT   = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   localparam logic [IDX_W:0] MAX_N    = (IDX_W+1)'(NUM_ENTRIES);
   localparam logic [2:0]     GEN_DONE = 3'd4;

   state_t            state_q;
   logic [IDX_W:0]    n_q;
   logic [LOOP_W-1:0] loops_q;

   logic [7:0]  tbl_f1_cnt    [NUM_ENTRIES];
   logic [7:0]  tbl_f2_cnt    [NUM_ENTRIES];
   logic [7:0]  tbl_stop_cnt  [NUM_ENTRIES];
   logic [15:0] tbl_f1_end    [NUM_ENTRIES];
   logic [15:0] tbl_f1_switch [NUM_ENTRIES];
   logic [15:0] tbl_f2_end    [NUM_ENTRIES];
   logic [15:0] tbl_f2_switch [NUM_ENTRIES];

   logic [IDX_W:0]    n_clamp;
   logic [IDX_W:0]    entry_nxt;
   logic [LOOP_W-1:0] loop_inc;
   logic              unused_wr_bits;

   assign n_clamp   = (num_entries_i > MAX_N) ? MAX_N : num_entries_i;
   assign entry_nxt = {1'b0, entry_o} + (IDX_W+1)'(1);
   // Saturating increment; only reachable at all-ones in loop-forever mode.
   assign loop_inc  = (&loop_o) ? loop_o : loop_o + LOOP_W'(1);

   assign busy_o  = (state_q != S_IDLE);
   assign state_o = state_q;

   // Low byte of field 0 carries no data.
   assign unused_wr_bits = ^wr_data_i[7:0];

   // Program table; frozen while a run is in progress.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            tbl_f1_cnt[i]    <= '0;
            tbl_f2_cnt[i]    <= '0;
            tbl_stop_cnt[i]  <= '0;
            tbl_f1_end[i]    <= '0;
            tbl_f1_switch[i] <= '0;
            tbl_f2_end[i]    <= '0;
            tbl_f2_switch[i] <= '0;
         end
      end else if (wr_en_i && !busy_o && (32'(wr_idx_i) < 32'(NUM_ENTRIES))) begin
         case (wr_field_i)
            2'd0: begin
               tbl_f1_cnt[wr_idx_i]   <= wr_data_i[31:24];
               tbl_f2_cnt[wr_idx_i]   <= wr_data_i[23:16];
               tbl_stop_cnt[wr_idx_i] <= wr_data_i[15:8];
            end
            2'd1: begin
               tbl_f1_end[wr_idx_i]    <= wr_data_i[31:16];
               tbl_f1_switch[wr_idx_i] <= wr_data_i[15:0];
            end
            2'd2: begin
               tbl_f2_end[wr_idx_i]    <= wr_data_i[31:16];
               tbl_f2_switch[wr_idx_i] <= wr_data_i[15:0];
            end
            default: ;
         endcase
      end
   end

   // Playback FSM with registered command/status outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= S_IDLE;
         n_q             <= '0;
         loops_q         <= '0;
         entry_o         <= '0;
         loop_o          <= '0;
         pls_start_o     <= 1'b0;
         pls_stop_o      <= 1'b0;
         done_o          <= 1'b0;
         aborted_o       <= 1'b0;
         pls_f1_cnt_o    <= '0;
         pls_f2_cnt_o    <= '0;
         pls_stop_cnt_o  <= '0;
         pls_f1_end_o    <= '0;
         pls_f1_switch_o <= '0;
         pls_f2_end_o    <= '0;
         pls_f2_switch_o <= '0;
      end else begin
         pls_start_o <= 1'b0;
         pls_stop_o  <= 1'b0;
         done_o      <= 1'b0;
         aborted_o   <= 1'b0;
         // Abort outranks every other transition. Because it replaces the
         // LOAD branch, start and stop can never be issued together.
         if (abort_i && state_q != S_IDLE) begin
            pls_stop_o <= 1'b1;
            aborted_o  <= 1'b1;
            state_q    <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (go_i) begin
                     entry_o <= '0;
                     loop_o  <= '0;
                     n_q     <= n_clamp;
                     loops_q <= loops_i;
                     if (n_clamp == '0) begin
                        done_o  <= 1'b1;
                        state_q <= S_FINISH;
                     end else begin
                        state_q <= S_LOAD;
                     end
                  end
               end
               S_LOAD: begin
                  pls_f1_cnt_o    <= tbl_f1_cnt[entry_o];
                  pls_f2_cnt_o    <= tbl_f2_cnt[entry_o];
                  pls_stop_cnt_o  <= tbl_stop_cnt[entry_o];
                  pls_f1_end_o    <= tbl_f1_end[entry_o];
                  pls_f1_switch_o <= tbl_f1_switch[entry_o];
                  pls_f2_end_o    <= tbl_f2_end[entry_o];
                  pls_f2_switch_o <= tbl_f2_switch[entry_o];
                  pls_start_o     <= 1'b1;
                  state_q         <= S_START;
               end
               S_START: state_q <= S_WAIT;
               S_WAIT: begin
                  if (pls_state_i == GEN_DONE) state_q <= S_NEXT;
               end
               S_NEXT: begin
                  if (entry_nxt < n_q) begin
                     entry_o <= entry_nxt[IDX_W-1:0];
                     state_q <= S_LOAD;
                  end else begin
                     loop_o <= loop_inc;
                     if (loops_q != '0 && loop_inc == loops_q) begin
                        done_o  <= 1'b1;
                        state_q <= S_FINISH;
                     end else begin
                        entry_o <= '0;
                        state_q <= S_LOAD;
                     end
                  end
               end
               S_FINISH: state_q <= S_IDLE;
               default:  state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_user_pulse_sequencer.sv
// -----------------------------------------------------------------------------
// tb_user_pulse_sequencer
//   Drives table writes and playback runs against a reference built from the
//   program rules. The expected playback is the list table[0..n-1] repeated
//   once per pass. A small generator stand-in answers each start with DONE
//   after a random delay, and the cycle timing of start/done is predicted from
//   the moment DONE is presented.
// -----------------------------------------------------------------------------
module tb_user_pulse_sequencer;

   localparam int NE = 8;
   localparam int IW = 3;
   localparam int LW = 8;

   // ---------------- clock / reset ----------------
   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   logic          wr_en_i;
   logic [IW-1:0] wr_idx_i;
   logic [1:0]    wr_field_i;
   logic [31:0]   wr_data_i;
   logic          go_i;
   logic          abort_i;
   logic [IW:0]   num_entries_i;
   logic [LW-1:0] loops_i;
   logic [2:0]    pls_state_i;
   logic          pls_start_o, pls_stop_o;
   logic [7:0]    pls_f1_cnt_o, pls_f2_cnt_o, pls_stop_cnt_o;
   logic [15:0]   pls_f1_end_o, pls_f1_switch_o, pls_f2_end_o, pls_f2_switch_o;
   logic          busy_o, done_o, aborted_o;
   logic [IW-1:0] entry_o;
   logic [LW-1:0] loop_o;
   logic [2:0]    state_o;

   user_pulse_sequencer #(.NUM_ENTRIES(NE), .LOOP_W(LW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i), .wr_field_i(wr_field_i), .wr_data_i(wr_data_i),
      .go_i(go_i), .abort_i(abort_i), .num_entries_i(num_entries_i), .loops_i(loops_i),
      .pls_state_i(pls_state_i),
      .pls_start_o(pls_start_o), .pls_stop_o(pls_stop_o),
      .pls_f1_cnt_o(pls_f1_cnt_o), .pls_f2_cnt_o(pls_f2_cnt_o), .pls_stop_cnt_o(pls_stop_cnt_o),
      .pls_f1_end_o(pls_f1_end_o), .pls_f1_switch_o(pls_f1_switch_o),
      .pls_f2_end_o(pls_f2_end_o), .pls_f2_switch_o(pls_f2_switch_o),
      .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
      .entry_o(entry_o), .loop_o(loop_o), .state_o(state_o)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   // Entry layout: {f1_cnt, f2_cnt, stop_cnt, f1_end, f1_switch, f2_end, f2_switch}
   logic [87:0] model_tbl [NE];
   logic [87:0] exp_q [$];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [87:0] dut_cfg();
      return {pls_f1_cnt_o, pls_f2_cnt_o, pls_stop_cnt_o, pls_f1_end_o,
              pls_f1_switch_o, pls_f2_end_o, pls_f2_switch_o};
   endfunction

   // ---------------- driver tasks ----------------
   // Each task starts and ends just after a falling edge.
   task automatic write_field(input int idx, input int fld, input logic [31:0] data);
      wr_en_i    = 1'b1;
      wr_idx_i   = IW'(idx);
      wr_field_i = 2'(fld);
      wr_data_i  = data;
      case (fld)
         0: model_tbl[idx][87:64] = data[31:8];
         1: model_tbl[idx][63:32] = data;
         2: model_tbl[idx][31:0]  = data;
         default: ;
      endcase
      @(negedge clk_i);
      wr_en_i = 1'b0;
   endtask

   task automatic play(input int n_raw, input int loops, input int abort_after,
                       input bit busy_wr, input bit go_abort);
      int n, passes, total, starts, pend, k, exp_start, exp_done, abort_cyc;
      bit finished, abort_next, abort_sent;
      n = (n_raw > NE) ? NE : n_raw;
      passes = (loops == 0) ? (abort_after / ((n > 0) ? n : 1) + 2) : loops;
      total = n * passes;
      exp_q.delete();
      for (int p = 0; p < passes; p++)
         for (int e = 0; e < n; e++) exp_q.push_back(model_tbl[e]);
      starts = 0; pend = -1; finished = 0; abort_next = 0; abort_sent = 0; abort_cyc = -10;
      exp_start = (n > 0) ? 2 : -1;
      exp_done  = (n == 0) ? 1 : -1;
      go_i = 1'b1;
      abort_i = go_abort;
      num_entries_i = (IW+1)'(n_raw);
      loops_i = LW'(loops);
      for (k = 1; k <= 3000 && !finished; k++) begin
         @(negedge clk_i);
         go_i = 1'b0; abort_i = 1'b0; wr_en_i = 1'b0;
         if (k == 1) begin
            check("busy_after_go", busy_o, 1);
            // Run parameters are latched at go; later changes must not matter.
            num_entries_i = (IW+1)'($urandom_range(0, 15));
            loops_i = LW'($urandom_range(0, 255));
         end
         if (pls_start_o && pls_stop_o) check("start_stop_overlap", 1, 0);
         if (aborted_o && !(abort_sent && k == abort_cyc + 1)) check("aborted_spurious", aborted_o, 0);
         if (pls_stop_o && !(abort_sent && k == abort_cyc + 1)) check("stop_spurious", pls_stop_o, 0);
         if (abort_sent && k == abort_cyc + 1) begin
            check("abort_stop", pls_stop_o, 1);
            check("abort_flag", aborted_o, 1);
            check("abort_no_done", done_o, 0);
            check("abort_idle", busy_o, 0);
            finished = 1;
         end else if (done_o) begin
            check("done_time", k, exp_done);
            check("done_loop", loop_o, (n == 0) ? 0 : loops);
            check("done_entry", entry_o, (n == 0) ? 0 : n - 1);
            check("done_no_start", pls_start_o, 0);
            finished = 1;
         end else if (pls_start_o) begin
            check("start_time", k, exp_start);
            if (exp_q.size() == 0) check("start_unexpected", 1, 0);
            else check("cfg", dut_cfg(), exp_q.pop_front());
            if (n > 0) begin
               check("start_entry", entry_o, starts % n);
               check("start_loop", loop_o, starts / n);
            end
            starts++;
            exp_start = -1;
            pls_state_i = 3'd1;
            if (busy_wr && starts == 1) begin
               wr_en_i = 1'b1; wr_idx_i = IW'(1); wr_field_i = 2'd0;
               wr_data_i = {~model_tbl[1][87:64], 8'h00};
            end
            if (starts == abort_after) abort_next = 1;
            else pend = $urandom_range(1, 4);
         end else if (abort_next) begin
            abort_i = 1'b1; abort_next = 0; abort_sent = 1; abort_cyc = k;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               pls_state_i = 3'd4;
               if (loops != 0 && starts == total) exp_done = k + 2;
               else exp_start = k + 3;
            end
         end
      end
      if (!finished) begin
         check("timeout", 0, 1);
         abort_i = 1'b1;
         @(negedge clk_i);
         abort_i = 1'b0;
      end
      pls_state_i = 3'd0;
      @(negedge clk_i);
      check("idle_after_run", {busy_o, state_o}, 0);
   endtask

   task automatic reset_mid_wait();
      bit seen;
      seen = 0;
      write_field(0, 0, 32'hAABB_CC00);
      go_i = 1'b1; num_entries_i = 4'd2; loops_i = 8'd1;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk_i);
         go_i = 1'b0;
         if (pls_start_o) seen = 1;
      end
      check("rst_test_start_seen", seen, 1);
      pls_state_i = 3'd1;
      @(negedge clk_i);
      check("rst_test_in_wait", busy_o, 1);
      rst_i = 1'b1;
      #1;
      check("rst_mid_cfg", dut_cfg(), 0);
      check("rst_mid_flags", {pls_start_o, pls_stop_o, done_o, aborted_o, busy_o}, 0);
      check("rst_mid_idx", {entry_o, loop_o, state_o}, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      pls_state_i = 3'd0;
      for (int e = 0; e < NE; e++) model_tbl[e] = '0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_i = 1'b1; wr_en_i = 1'b0; wr_idx_i = '0; wr_field_i = '0; wr_data_i = '0;
      go_i = 1'b0; abort_i = 1'b0; num_entries_i = '0; loops_i = '0; pls_state_i = '0;
      for (int e = 0; e < NE; e++) model_tbl[e] = '0;
      repeat (3) @(negedge clk_i);
      check("rst_cfg", dut_cfg(), 0);
      check("rst_flags", {pls_start_o, pls_stop_o, done_o, aborted_o, busy_o}, 0);
      check("rst_idx", {entry_o, loop_o, state_o}, 0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // abort while idle does nothing
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      check("idle_abort_ignored", {pls_stop_o, aborted_o, busy_o}, 0);

      // single entry, single pass
      write_field(0, 0, 32'h0200_0000);
      write_field(0, 1, 32'h0004_0002);
      play(1, 1, -1, 0, 0);

      // three distinct entries, two passes
      write_field(0, 2, 32'h0011_0022);
      write_field(1, 0, 32'h0305_0700);
      write_field(1, 1, 32'h1234_5678);
      write_field(2, 0, 32'h0A0B_0C00);
      write_field(2, 2, 32'h9ABC_DEF0);
      write_field(2, 3, 32'hFFFF_FFFF);
      play(3, 2, -1, 0, 0);

      // loop forever, abort in WAIT
      play(2, 0, 5, 0, 0);

      // empty program
      play(0, 1, -1, 0, 0);

      // write while busy is dropped; a second run shows the old values
      play(2, 1, -1, 1, 0);
      play(2, 1, -1, 0, 0);

      // over-range entry count clamps; go with abort in idle still starts
      for (int e = 3; e < NE; e++) write_field(e, $urandom_range(0, 2), $urandom());
      play(12, 1, -1, 0, 1);

      // reset in the middle of a run clears the table
      reset_mid_wait();
      play(3, 1, -1, 0, 0);

      // randomized programs
      repeat (4) begin
         repeat (8) write_field($urandom_range(0, NE-1), $urandom_range(0, 3), $urandom());
         play($urandom_range(0, 12), $urandom_range(1, 3), -1, 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no end of test, expected end before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
